params_reporter: RTL and testbench

PARAMS_REPORTER -- requirements
Module: params_reporter

---
 rtl/params_pkg.sv | 35 +++
 rtl/params_reporter_if.sv | 26 ++
 rtl/params_frame_rom.sv | 57 +++++
 rtl/params_reporter.sv | 127 ++++++++++++
 tb/tb_params_reporter.sv | 175 +++++++++++++++++
 5 files changed

// File: rtl/params_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : params_pkg
//  Description : Shared constants, FSM state type and helpers for the
//                parameter reporter.
//  Revision    : 1.0 - initial release
// ============================================================================
package params_pkg;

    localparam logic [7:0] c_header       = 8'hA5;
    localparam int         c_flag_boo_bit = 0;
    localparam int         c_flag_log_bit = 1;
    localparam int         c_flag_rea_bit = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int ceil_bytes(input int width);
        return (width + 7) / 8;
    endfunction

    function automatic logic [7:0] flag_byte(input logic boo, input logic lg, input logic rea_nz);
        logic [7:0] f;
        f                 = 8'h00;
        f[c_flag_boo_bit] = boo;
        f[c_flag_log_bit] = lg;
        f[c_flag_rea_bit] = rea_nz;
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/params_reporter_if.sv
`default_nettype none
// ============================================================================
//  Module      : params_reporter_if
//  Description : Start/handshake/status bundle between the reporter and its sink.
//  Revision    : 1.0 - initial release
// ============================================================================
interface params_reporter_if;
    logic       start_i;
    logic       ready_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       busy_o;
    logic       done_o;
    logic       ok_o;

    modport master (
        output start_i, ready_i,
        input  data_o, valid_o, busy_o, done_o, ok_o
    );

    modport slave (
        input  start_i, ready_i,
        output data_o, valid_o, busy_o, done_o, ok_o
    );
endinterface
`default_nettype wire

// File: rtl/params_frame_rom.sv
`default_nettype none
// ============================================================================
//  Module      : params_frame_rom
//  Description : Combinational map from frame index to frame byte, built
//                entirely from the reported parameters.
//  Revision    : 1.0 - initial release
// ============================================================================
module params_frame_rom
    import params_pkg::*;
#(
    parameter int                    BOO     = 1,
    parameter int                    INT_W   = 16,
    parameter logic [INT_W-1:0]      INT     = INT_W'(1),
    parameter logic                  LOG     = 1'b1,
    parameter int                    VW      = 8,
    parameter logic [VW-1:0]         VEC     = '0,
    parameter int                    STR_LEN = 4,
    parameter logic [STR_LEN*8-1:0]  STR     = "ABCD",
    parameter real                   REA     = 1.0,
    parameter int                    IDX_W   = 4
) (
    input  wire logic [IDX_W-1:0] i_idx,
    output logic      [7:0]       o_byte
);

    localparam int          c_ni       = ceil_bytes(INT_W);
    localparam int          c_nv       = ceil_bytes(VW);
    localparam int          c_len_data = 2 + c_ni + c_nv + STR_LEN;
    localparam int          c_depth    = 1 << IDX_W;
    localparam logic [63:0] c_int64    = 64'(INT);
    localparam logic [63:0] c_vec64    = 64'(VEC);
    localparam logic [7:0]  c_flags    = flag_byte(BOO != 0, LOG, REA != 0.0);

    logic [7:0] w_rom [c_depth];

    // Table spans the full index range so any counter value reads a defined byte.
    for (genvar g = 0; g < c_depth; g++) begin : g_rom
        if (g == 0) begin : g_hdr
            assign w_rom[g] = c_header;
        end else if (g == 1) begin : g_flags
            assign w_rom[g] = c_flags;
        end else if (g < 2 + c_ni) begin : g_int
            assign w_rom[g] = c_int64[(g-2)*8 +: 8];
        end else if (g < 2 + c_ni + c_nv) begin : g_vec
            assign w_rom[g] = c_vec64[(g-2-c_ni)*8 +: 8];
        end else if (g < c_len_data) begin : g_str
            // First character sits in the most significant byte of STR.
            assign w_rom[g] = STR[(c_len_data-1-g)*8 +: 8];
        end else begin : g_pad
            assign w_rom[g] = 8'h00;
        end
    end

    assign o_byte = w_rom[i_idx];

endmodule
`default_nettype wire

// File: rtl/params_reporter.sv
`default_nettype none
// ============================================================================
//  Module      : params_reporter
//  Description : Streams a byte frame describing its parameters on request.
//                Define PARAMS_CHECKSUM_EN to append an XOR checksum byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module params_reporter
    import params_pkg::*;
#(
    parameter int                    BOO     = 1,
    parameter int                    INT_W   = 16,
    parameter logic [INT_W-1:0]      INT     = INT_W'(1),
    parameter logic                  LOG     = 1'b1,
    parameter int                    VW      = 8,
    parameter logic [VW-1:0]         VEC     = '0,
    parameter int                    STR_LEN = 4,
    parameter logic [STR_LEN*8-1:0]  STR     = "ABCD",
    parameter real                   REA     = 1.0
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    params_reporter_if.slave  bus
);

    localparam int c_len_data = 2 + ceil_bytes(INT_W) + ceil_bytes(VW) + STR_LEN;
`ifdef PARAMS_CHECKSUM_EN
    localparam int c_len = c_len_data + 1;
`else
    localparam int c_len = c_len_data;
`endif
    localparam int                 c_idx_w = $clog2(c_len + 1);
    localparam logic [c_idx_w-1:0] c_last  = c_idx_w'(c_len - 1);

    state_t             r_state;
    state_t             w_next;
    logic [c_idx_w-1:0] r_idx;
    logic [7:0]         w_rom_byte;
    logic [7:0]         w_byte;
    logic               w_accept;
    logic               w_last;

    params_frame_rom #(
        .BOO     (BOO),
        .INT_W   (INT_W),
        .INT     (INT),
        .LOG     (LOG),
        .VW      (VW),
        .VEC     (VEC),
        .STR_LEN (STR_LEN),
        .STR     (STR),
        .REA     (REA),
        .IDX_W   (c_idx_w)
    ) u_rom (
        .i_idx  (r_idx),
        .o_byte (w_rom_byte)
    );

    assign w_accept = (r_state == ST_SEND) && bus.ready_i;
    assign w_last   = (r_idx == c_last);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Index returns to zero on the final acceptance, so it never passes c_last.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_idx <= '0;
        end else if (w_accept) begin
            r_idx <= w_last ? '0 : r_idx + 1'b1;
        end
    end

`ifdef PARAMS_CHECKSUM_EN
    logic [7:0] r_csum;

    always_ff @(posedge clk_i) begin
        if (rst_i || (r_state == ST_IDLE)) begin
            r_csum <= 8'h00;
        end else if (w_accept) begin
            r_csum <= r_csum ^ w_byte;
        end
    end

    assign w_byte = w_last ? r_csum : w_rom_byte;
`else
    assign w_byte = w_rom_byte;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.start_i)         w_next = ST_SEND;
            ST_SEND: if (w_accept && w_last)  w_next = ST_DONE;
            ST_DONE:                          w_next = ST_IDLE;
            default:                          w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.valid_o = 1'b0;
        bus.busy_o  = 1'b0;
        bus.done_o  = 1'b0;
        bus.data_o  = 8'h00;
        case (r_state)
            ST_SEND: begin
                bus.valid_o = 1'b1;
                bus.busy_o  = 1'b1;
                bus.data_o  = w_byte;
            end
            ST_DONE: begin
                bus.busy_o  = 1'b1;
                bus.done_o  = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.ok_o = (BOO != 0) && (INT != '0);

endmodule
`default_nettype wire

// File: tb/tb_params_reporter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_params_reporter
//  Description : Directed, table-driven bench for params_reporter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_params_reporter;

    typedef struct {
        logic       rst;
        logic       start;
        logic       ready;
        logic       valid;
        logic [7:0] data;
        logic       busy;
        logic       done;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    vec_t tbl[$];

    // Default frame; with the checksum build the XOR of these nine bytes is A7.
    logic [7:0] frame0[$] = '{8'hA5, 8'h07, 8'h01, 8'h00, 8'h00, 8'h41, 8'h42, 8'h43, 8'h44};
    logic [7:0] frame1[$] = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h05, 8'h5A};

    params_reporter_if bus0 ();
    params_reporter_if bus1 ();

    params_reporter dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus0)
    );

    params_reporter #(
        .BOO     (0),
        .INT_W   (12),
        .INT     (12'd0),
        .VW      (3),
        .VEC     (3'd5),
        .STR_LEN (1),
        .STR     ("Z"),
        .REA     (0.0)
    ) dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic rd);
        rst          = r;
        bus0.start_i = s;
        bus1.start_i = s;
        bus0.ready_i = rd;
        bus1.ready_i = rd;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic s, input logic rd,
                       input logic v, input logic [7:0] d, input logic b, input logic dn);
        vec_t x;
        x.rst = r; x.start = s; x.ready = rd;
        x.valid = v; x.data = d; x.busy = b; x.done = dn;
        tbl.push_back(x);
    endtask

    // mode 0: single start pulse, 1: start held throughout, 2: extra starts mid-frame
    task automatic add_frame(input int mode, input int stall_idx);
        logic s;
        add(1'b0, 1'b1, 1'b1, 1'b1, frame0[0], 1'b1, 1'b0);
        for (int i = 1; i < frame0.size(); i++) begin
            s = (mode == 1) || ((mode == 2) && (i == 3 || i == 6));
            add(1'b0, s, 1'b1, 1'b1, frame0[i], 1'b1, 1'b0);
            if (i == stall_idx) begin
                for (int k = 0; k < 3; k++) add(1'b0, s, 1'b0, 1'b1, frame0[i], 1'b1, 1'b0);
            end
        end
        s = (mode == 1);
        add(1'b0, s, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        add(1'b0, s, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus0.start_i = 1'b0; bus0.ready_i = 1'b1;
        bus1.start_i = 1'b0; bus1.ready_i = 1'b1;
`ifdef PARAMS_CHECKSUM_EN
        frame0.push_back(8'hA7);
        frame1.push_back(8'hF8);
`endif

        check("ok_default", {7'b0, bus0.ok_o}, 8'h01);
        check("ok_zero",    {7'b0, bus1.ok_o}, 8'h00);

        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        add_frame(0, -1);
        add_frame(0, 2);
        add_frame(2, -1);
        add(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        add_frame(1, -1);
        add(1'b0, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b1, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].start, tbl[i].ready);
            check($sformatf("row%0d.valid", i), {7'b0, bus0.valid_o}, {7'b0, tbl[i].valid});
            check($sformatf("row%0d.data",  i), bus0.data_o,          tbl[i].data);
            check($sformatf("row%0d.busy",  i), {7'b0, bus0.busy_o},  {7'b0, tbl[i].busy});
            check($sformatf("row%0d.done",  i), {7'b0, bus0.done_o},  {7'b0, tbl[i].done});
        end

        // Reset while byte 5 is presented aborts the frame silently.
        step(1'b0, 1'b1, 1'b1);
        check("abort.hdr", bus0.data_o, 8'hA5);
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 1'b0, 1'b1);
            check($sformatf("abort.b%0d", i), bus0.data_o, frame0[i]);
        end
        step(1'b1, 1'b0, 1'b1);
        check("abort.valid", {7'b0, bus0.valid_o}, 8'h00);
        check("abort.done",  {7'b0, bus0.done_o},  8'h00);
        check("abort.busy",  {7'b0, bus0.busy_o},  8'h00);
        check("abort.data",  bus0.data_o,          8'h00);
        step(1'b0, 1'b0, 1'b1);
        check("abort.nodone", {7'b0, bus0.done_o}, 8'h00);
        step(1'b0, 1'b1, 1'b1);
        check("restart.hdr", bus0.data_o, 8'hA5);
        for (int i = 1; i < frame0.size(); i++) begin
            step(1'b0, 1'b0, 1'b1);
            check($sformatf("restart.b%0d", i), bus0.data_o, frame0[i]);
            check($sformatf("restart.v%0d", i), {7'b0, bus0.valid_o}, 8'h01);
        end
        step(1'b0, 1'b0, 1'b1);
        check("restart.done", {7'b0, bus0.done_o}, 8'h01);
        step(1'b0, 1'b0, 1'b1);
        check("restart.idle", {7'b0, bus0.busy_o}, 8'h00);

        // Non-default parameter set.
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check("alt.hdr", bus1.data_o, frame1[0]);
        for (int i = 1; i < frame1.size(); i++) begin
            step(1'b0, 1'b0, 1'b1);
            check($sformatf("alt.b%0d", i), bus1.data_o, frame1[i]);
        end
        step(1'b0, 1'b0, 1'b1);
        check("alt.done",  {7'b0, bus1.done_o},  8'h01);
        check("alt.valid", {7'b0, bus1.valid_o}, 8'h00);
        step(1'b0, 1'b0, 1'b1);
        check("alt.idle",  {7'b0, bus1.busy_o},  8'h00);
        check("alt.ok",    {7'b0, bus1.ok_o},    8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
